// File: rtl/bet_entry_multi.sv
// bet_entry_multi: multi-line bet entry. A line count is scanned first, then
// LINES lines of PICKS ascending numbers, one number per scan strobe. Every
// completed line is stored in a small line buffer. A registered read port
// exposes the stored lines to the draw/compare logic downstream.
module bet_entry_multi #(
   parameter  int NUM_W     = 5,
   parameter  int PICKS     = 4,
   parameter  int MAX_LINES = 4,
   parameter  int MAX_VAL   = 30,
   localparam int LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1,
   localparam int PW        = (PICKS > 1) ? $clog2(PICKS) : 1,
   localparam int BW        = PICKS * NUM_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SYSRDY,
   input  logic              scan,
   input  logic [NUM_W-1:0]  N_in,
   input  logic [LW-1:0]     rd_line,
   output logic [BW-1:0]     B_bus,
   output logic [BW-1:0]     rd_bet,
   output logic [PW-1:0]     number,
   output logic [LW-1:0]     line_idx,
   output logic [LW:0]       lines_tot,
   output logic              RD_ERR,
   output logic              Set,
   output logic              V,
   output logic              finish
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LINES = 2'd1;
   localparam logic [1:0] S_PICK  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [NUM_W-1:0] MAX_VAL_N   = NUM_W'(MAX_VAL);
   localparam logic [NUM_W-1:0] MAX_LINES_N = NUM_W'(MAX_LINES);
   localparam logic [PW-1:0]    LAST_PICK   = PW'(PICKS - 1);
   localparam logic [PW-1:0]    PICK_ONE    = PW'(1);
   localparam logic [LW-1:0]    LINE_ONE    = LW'(1);
   localparam logic [LW:0]      TOT_ONE     = (LW + 1)'(1);

   logic [1:0]       r_state;
   logic             r_scan_q;
   logic [BW-1:0]    r_buf [MAX_LINES];

   logic             w_scan_ev;
   logic [NUM_W-1:0] w_prev;
   logic [BW-1:0]    w_line_next;
   logic             w_cnt_ok;
   logic             w_pick_ok;
   logic             w_last_pick;
   logic             w_last_line;
   logic             w_store;

   // A held strobe yields exactly one event: only the low-to-high transition counts.
   assign w_scan_ev = scan & ~r_scan_q;

   // Pick-slot decode: previous pick for the ascending check, and the line
   // with the current pick dropped into its slot.
   always_comb begin
      w_prev      = '0;
      w_line_next = B_bus;
      for (int k = 0; k < PICKS; k++) begin
         if (int'(number) == k) begin
            w_line_next[k*NUM_W +: NUM_W] = N_in;
            if (k > 0) begin
               w_prev = B_bus[(k-1)*NUM_W +: NUM_W];
            end
         end
      end
   end

   // Validity of the scanned value as a line count or as the next pick.
   always_comb begin
      w_cnt_ok    = (N_in != '0) && (N_in <= MAX_LINES_N);
      w_pick_ok   = (N_in != '0) && (N_in <= MAX_VAL_N) &&
                    ((number == '0) || (N_in > w_prev));
      w_last_pick = (number == LAST_PICK);
      w_last_line = ({1'b0, line_idx} == (lines_tot - TOT_ONE));
      // SYSRDY low wins over a simultaneous scan, so it gates the store too.
      w_store     = SYSRDY && (r_state == S_PICK) && w_scan_ev &&
                    w_pick_ok && w_last_pick;
   end

   // Scan strobe history for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_q <= 1'b0;
      end else begin
         r_scan_q <= scan;
      end
   end

   // Line buffer: a completed line lands at line_idx; contents survive SYSRDY drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_LINES; i++) begin
            r_buf[i] <= '0;
         end
      end else if (w_store) begin
         r_buf[line_idx] <= w_line_next;
      end
   end

   // Registered read port; a same-cycle write is not forwarded (old data returned).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_bet <= '0;
      end else if (int'(rd_line) < MAX_LINES) begin
         rd_bet <= r_buf[rd_line];
      end else begin
         rd_bet <= '0;
      end
   end

   // Entry sequencer: line count, then picks line by line, then hold in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         B_bus     <= '0;
         number    <= '0;
         line_idx  <= '0;
         lines_tot <= '0;
         RD_ERR    <= 1'b0;
         Set       <= 1'b0;
         V         <= 1'b0;
         finish    <= 1'b0;
      end else if (!SYSRDY) begin
         // Abandon the bet in progress; IDLE is already in this cleared state.
         r_state   <= S_IDLE;
         B_bus     <= '0;
         number    <= '0;
         line_idx  <= '0;
         lines_tot <= '0;
         RD_ERR    <= 1'b0;
         Set       <= 1'b0;
         V         <= 1'b0;
         finish    <= 1'b0;
      end else begin
         Set <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_LINES;
            end
            S_LINES: begin
               if (w_scan_ev) begin
                  if (w_cnt_ok) begin
                     lines_tot <= (LW + 1)'(N_in);
                     V         <= 1'b1;
                     RD_ERR    <= 1'b0;
                     r_state   <= S_PICK;
                  end else begin
                     RD_ERR <= 1'b1;
                  end
               end
            end
            S_PICK: begin
               if (w_scan_ev) begin
                  if (!w_pick_ok) begin
                     // Slot is left as is so the user simply rescans it.
                     RD_ERR <= 1'b1;
                  end else begin
                     RD_ERR <= 1'b0;
                     if (w_last_pick) begin
                        Set    <= 1'b1;
                        number <= '0;
                        B_bus  <= '0;
                        if (w_last_line) begin
                           finish  <= 1'b1;
                           r_state <= S_DONE;
                        end else begin
                           line_idx <= line_idx + LINE_ONE;
                        end
                     end else begin
                        B_bus  <= w_line_next;
                        number <= number + PICK_ONE;
                     end
                  end
               end
            end
            S_DONE: begin
               // Bet complete: ignore scans until SYSRDY drops or reset.
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bet_entry_multi.sv
// Directed bench for bet_entry_multi with hand-computed expectations.
module tb_bet_entry_multi;
   localparam int NUM_W = 5;
   localparam int PICKS = 4;
   localparam int MAX_LINES = 4;
   localparam int MAX_VAL = 30;
   localparam int LW = 2;
   localparam int PW = 2;
   localparam int BW = 20;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             SYSRDY = 1'b0;
   logic             scan = 1'b0;
   logic [NUM_W-1:0] N_in = '0;
   logic [LW-1:0]    rd_line = '0;
   logic [BW-1:0]    B_bus;
   logic [BW-1:0]    rd_bet;
   logic [PW-1:0]    number;
   logic [LW-1:0]    line_idx;
   logic [LW:0]      lines_tot;
   logic             RD_ERR;
   logic             Set;
   logic             V;
   logic             finish;

   int checks = 0;
   int errors = 0;

   bet_entry_multi #(
      .NUM_W(NUM_W), .PICKS(PICKS), .MAX_LINES(MAX_LINES), .MAX_VAL(MAX_VAL)
   ) dut (
      .clk(clk), .reset(reset), .SYSRDY(SYSRDY), .scan(scan), .N_in(N_in),
      .rd_line(rd_line), .B_bus(B_bus), .rd_bet(rd_bet), .number(number),
      .line_idx(line_idx), .lines_tot(lines_tot), .RD_ERR(RD_ERR), .Set(Set),
      .V(V), .finish(finish)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] pk(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] d);
      return {d, c, b, a};
   endfunction

   task automatic check_status(input string tag, input int num, input int li, input int lt,
                               input int err, input int s, input int vv, input int fin,
                               input logic [BW-1:0] bus);
      check({tag, ".number"}, 32'(number), 32'(num));
      check({tag, ".line_idx"}, 32'(line_idx), 32'(li));
      check({tag, ".lines_tot"}, 32'(lines_tot), 32'(lt));
      check({tag, ".RD_ERR"}, 32'(RD_ERR), 32'(err));
      check({tag, ".Set"}, 32'(Set), 32'(s));
      check({tag, ".V"}, 32'(V), 32'(vv));
      check({tag, ".finish"}, 32'(finish), 32'(fin));
      check({tag, ".B_bus"}, 32'(B_bus), 32'(bus));
   endtask

   // One clean scan pulse: raised at a falling edge, acted on at the next
   // rising edge, dropped at the following falling edge (outputs then valid).
   task automatic scan_val(input logic [4:0] v);
      @(negedge clk);
      N_in = v;
      scan = 1'b1;
      @(negedge clk);
      scan = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check_status("rst", 0, 0, 0, 0, 0, 0, 0, '0);
      check("rst.rd_bet", 32'(rd_bet), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      SYSRDY = 1'b1;
      @(negedge clk);

      // Illegal line counts.
      scan_val(5'd0);
      check("cnt0.RD_ERR", 32'(RD_ERR), 32'd1);
      check("cnt0.V", 32'(V), 32'd0);
      scan_val(5'd5);
      check("cnt5.RD_ERR", 32'(RD_ERR), 32'd1);
      check("cnt5.V", 32'(V), 32'd0);

      // Bet of two lines.
      scan_val(5'd2);
      check_status("cnt2", 0, 0, 2, 0, 0, 1, 0, '0);
      scan_val(5'd5);
      check_status("p5", 1, 0, 2, 0, 0, 1, 0, pk(5, 0, 0, 0));
      scan_val(5'd21);
      check_status("p21", 2, 0, 2, 0, 0, 1, 0, pk(5, 21, 0, 0));
      scan_val(5'd24);
      check_status("p24", 3, 0, 2, 0, 0, 1, 0, pk(5, 21, 24, 0));
      scan_val(5'd28);
      check_status("p28", 0, 1, 2, 0, 1, 1, 0, '0);
      rd_line = 2'd0;
      @(negedge clk);
      check("line0.Set_drop", 32'(Set), 32'd0);
      check("line0.rd_bet", 32'(rd_bet), 32'(pk(5, 21, 24, 28)));

      scan_val(5'd1);
      scan_val(5'd3);
      scan_val(5'd22);
      check_status("p22", 3, 1, 2, 0, 0, 1, 0, pk(1, 3, 22, 0));
      scan_val(5'd26);
      check_status("p26", 0, 1, 2, 0, 1, 1, 1, '0);
      rd_line = 2'd1;
      @(negedge clk);
      check("line1.rd_bet", 32'(rd_bet), 32'(pk(1, 3, 22, 26)));

      // DONE ignores scans, including ones that would be errors.
      scan_val(5'd10);
      check_status("done10", 0, 1, 2, 0, 0, 1, 1, '0);
      scan_val(5'd0);
      check_status("done0", 0, 1, 2, 0, 0, 1, 1, '0);
      rd_line = 2'd0;
      @(negedge clk);
      check("done.rd_bet0", 32'(rd_bet), 32'(pk(5, 21, 24, 28)));

      // SYSRDY drop from DONE clears status.
      SYSRDY = 1'b0;
      @(negedge clk);
      check_status("drop_done", 0, 0, 0, 0, 0, 0, 0, '0);
      SYSRDY = 1'b1;
      @(negedge clk);

      // Pick error cases.
      scan_val(5'd4);
      check_status("cnt4", 0, 0, 4, 0, 0, 1, 0, '0);
      scan_val(5'd7);
      check_status("e7", 1, 0, 4, 0, 0, 1, 0, pk(7, 0, 0, 0));
      scan_val(5'd7);
      check_status("e7dup", 1, 0, 4, 1, 0, 1, 0, pk(7, 0, 0, 0));
      scan_val(5'd31);
      check_status("e31", 1, 0, 4, 1, 0, 1, 0, pk(7, 0, 0, 0));
      scan_val(5'd0);
      check_status("e0", 1, 0, 4, 1, 0, 1, 0, pk(7, 0, 0, 0));
      scan_val(5'd9);
      check_status("e9", 2, 0, 4, 0, 0, 1, 0, pk(7, 9, 0, 0));

      // Held scan: only the first value may be taken even as N_in changes.
      @(negedge clk);
      N_in = 5'd12;
      scan = 1'b1;
      @(negedge clk);
      N_in = 5'd20;
      repeat (9) @(negedge clk);
      scan = 1'b0;
      check_status("held", 3, 0, 4, 0, 0, 1, 0, pk(7, 9, 12, 0));
      scan_val(5'd20);
      check_status("p20", 0, 1, 4, 0, 1, 1, 0, '0);
      rd_line = 2'd0;
      @(negedge clk);
      check("held.rd_bet", 32'(rd_bet), 32'(pk(7, 9, 12, 20)));

      // One-cycle SYSRDY drop mid-line.
      scan_val(5'd2);
      check_status("mid2", 1, 1, 4, 0, 0, 1, 0, pk(2, 0, 0, 0));
      @(negedge clk);
      SYSRDY = 1'b0;
      @(negedge clk);
      check_status("mid_drop", 0, 0, 0, 0, 0, 0, 0, '0);
      SYSRDY = 1'b1;
      @(negedge clk);
      scan_val(5'd3);
      check_status("recnt3", 0, 0, 3, 0, 0, 1, 0, '0);

      // SYSRDY drop on the same edge as a scan event: the scan is dropped.
      scan_val(5'd4);
      check("sim.pre_number", 32'(number), 32'd1);
      @(negedge clk);
      N_in = 5'd5;
      scan = 1'b1;
      SYSRDY = 1'b0;
      @(negedge clk);
      scan = 1'b0;
      check_status("sim", 0, 0, 0, 0, 0, 0, 0, '0);
      SYSRDY = 1'b1;
      @(negedge clk);

      // Asynchronous reset mid-line, between clock edges.
      scan_val(5'd3);
      scan_val(5'd6);
      check_status("pre_arst", 1, 0, 3, 0, 0, 1, 0, pk(6, 0, 0, 0));
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_status("arst", 0, 0, 0, 0, 0, 0, 0, '0);
      check("arst.rd_bet", 32'(rd_bet), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rd_line = 2'd0;
      @(negedge clk);
      @(negedge clk);
      check("arst.buf0", 32'(rd_bet), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
